// File: rtl/cpm_reg_bus_master.sv
// cpm_reg_bus_master: queues register commands and issues them one at a time on a req/gnt bus.
// Optional gnt timeout: define CPM_REG_MASTER_TIMEOUT_EN to abort a request after TIMEOUT_CYCLES.
module cpm_reg_bus_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [7:0]                       cmd_addr,
  input  logic [31:0]                      cmd_wdata,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic                             rsp_write,
  output logic [31:0]                      rsp_rdata,
  output logic                             rsp_err,
  output logic                             req,
  input  logic                             gnt,
  output logic                             write_en,
  output logic [7:0]                       addr,
  output logic [31:0]                      wdata,
  input  logic [31:0]                      rdata,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t         state_r, state_nxt_s;

  logic           fifo_write_r [FIFO_DEPTH];
  logic [7:0]     fifo_addr_r  [FIFO_DEPTH];
  logic [31:0]    fifo_wdata_r [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]  count_r, count_nxt_s;

  logic           push_s, pop_s;
  logic           head_write_s;
  logic [7:0]     head_addr_s;
  logic [31:0]    head_wdata_s;

  logic           req_r, req_s;
  logic           write_en_r, write_en_s;
  logic [7:0]     addr_r, addr_s;
  logic [31:0]    wdata_r, wdata_s;
  logic           rsp_valid_r, rsp_valid_s;
  logic           rsp_write_r, rsp_write_s;
  logic [31:0]    rsp_rdata_r, rsp_rdata_s;
  logic           busy_r, busy_nxt_s;
  logic           cmd_ready_r, cmd_ready_nxt_s;

  // The head is only popped from IDLE, so at most one command is ever in flight.
  assign push_s       = cmd_valid && cmd_ready_r;
  assign pop_s        = (state_r == ST_IDLE) && (count_r != CNT_ZERO);
  assign head_write_s = fifo_write_r[rd_ptr_r];
  assign head_addr_s  = fifo_addr_r[rd_ptr_r];
  assign head_wdata_s = fifo_wdata_r[rd_ptr_r];

  // Occupancy after this edge's push/pop.
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Command storage; contents are don't-care until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_write_r[wr_ptr_r] <= cmd_write;
      fifo_addr_r[wr_ptr_r]  <= cmd_addr;
      fifo_wdata_r[wr_ptr_r] <= cmd_wdata;
    end
  end

  // FIFO pointers and count; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_nxt_s;
    end
  end

`ifdef CPM_REG_MASTER_TIMEOUT_EN
  logic [9:0] wait_cnt_r;
  logic       timeout_s;
  logic       rsp_err_r, rsp_err_s;

  assign timeout_s = (wait_cnt_r == 10'(TIMEOUT_CYCLES - 1));

  // Counts REQ cycles spent without gnt; cleared as each request is launched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= 10'd0;
    end else if (pop_s) begin
      wait_cnt_r <= 10'd0;
    end else if ((state_r == ST_REQ) && !gnt) begin
      wait_cnt_r <= wait_cnt_r + 10'd1;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; gnt wins over a timeout reached in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (count_r != CNT_ZERO) state_nxt_s = ST_REQ;
        else                     state_nxt_s = ST_IDLE;
      end
      ST_REQ: begin
        if (gnt)            state_nxt_s = ST_RESP;
`ifdef CPM_REG_MASTER_TIMEOUT_EN
        else if (timeout_s) state_nxt_s = ST_RESP;
`endif
        else                state_nxt_s = ST_REQ;
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_RESP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered bus and response outputs.
  always_comb begin
    req_s       = req_r;
    write_en_s  = write_en_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    rsp_valid_s = rsp_valid_r;
    rsp_write_s = rsp_write_r;
    rsp_rdata_s = rsp_rdata_r;
`ifdef CPM_REG_MASTER_TIMEOUT_EN
    rsp_err_s   = rsp_err_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          req_s      = 1'b1;
          write_en_s = head_write_s;
          addr_s     = head_addr_s;
          wdata_s    = head_wdata_s;
        end else begin
          req_s      = 1'b0;
          write_en_s = 1'b0;
          addr_s     = 8'h00;
          wdata_s    = 32'h0000_0000;
        end
      end
      ST_REQ: begin
        if (gnt) begin
          req_s       = 1'b0;
          write_en_s  = 1'b0;
          addr_s      = 8'h00;
          wdata_s     = 32'h0000_0000;
          rsp_valid_s = 1'b1;
          rsp_write_s = write_en_r;
          rsp_rdata_s = write_en_r ? 32'h0000_0000 : rdata;
`ifdef CPM_REG_MASTER_TIMEOUT_EN
          rsp_err_s   = 1'b0;
        end else if (timeout_s) begin
          req_s       = 1'b0;
          write_en_s  = 1'b0;
          addr_s      = 8'h00;
          wdata_s     = 32'h0000_0000;
          rsp_valid_s = 1'b1;
          rsp_write_s = write_en_r;
          rsp_rdata_s = 32'h0000_0000;
          rsp_err_s   = 1'b1;
`endif
        end else begin
          req_s = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_s = 1'b0;
          rsp_write_s = 1'b0;
          rsp_rdata_s = 32'h0000_0000;
`ifdef CPM_REG_MASTER_TIMEOUT_EN
          rsp_err_s   = 1'b0;
`endif
        end else begin
          rsp_valid_s = 1'b1;
        end
      end
      default: begin
        req_s       = 1'b0;
        write_en_s  = 1'b0;
        addr_s      = 8'h00;
        wdata_s     = 32'h0000_0000;
        rsp_valid_s = 1'b0;
        rsp_write_s = 1'b0;
        rsp_rdata_s = 32'h0000_0000;
`ifdef CPM_REG_MASTER_TIMEOUT_EN
        rsp_err_s   = 1'b0;
`endif
      end
    endcase
  end

  assign busy_nxt_s      = (state_nxt_s != ST_IDLE) || (count_nxt_s != CNT_ZERO);
  assign cmd_ready_nxt_s = (count_nxt_s < CNT_DEPTH);

  // Output registers; cmd_ready is the only output that resets high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_r       <= 1'b0;
      write_en_r  <= 1'b0;
      addr_r      <= 8'h00;
      wdata_r     <= 32'h0000_0000;
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      busy_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      req_r       <= req_s;
      write_en_r  <= write_en_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_write_r <= rsp_write_s;
      rsp_rdata_r <= rsp_rdata_s;
      busy_r      <= busy_nxt_s;
      cmd_ready_r <= cmd_ready_nxt_s;
    end
  end

`ifdef CPM_REG_MASTER_TIMEOUT_EN
  // Abort flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err_r <= 1'b0;
    end else begin
      rsp_err_r <= rsp_err_s;
    end
  end
  assign rsp_err = rsp_err_r;
`else
  assign rsp_err = 1'b0;
`endif

  assign req        = req_r;
  assign write_en   = write_en_r;
  assign addr       = addr_r;
  assign wdata      = wdata_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_write  = rsp_write_r;
  assign rsp_rdata  = rsp_rdata_r;
  assign busy       = busy_r;
  assign cmd_ready  = cmd_ready_r;
  assign fifo_count = count_r;

endmodule

// File: tb/tb_cpm_reg_bus_master.sv
// Bench for cpm_reg_bus_master: transaction-level model checked every cycle plus directed literal checks.
module tb_cpm_reg_bus_master;
  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 8;
  localparam int CW             = $clog2(FIFO_DEPTH + 1);
`ifdef CPM_REG_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [7:0]    cmd_addr = 8'h00;
  logic [31:0]   cmd_wdata = 32'h0;
  logic          rsp_ready = 1'b1, gnt = 1'b0;
  logic          cmd_ready, rsp_valid, rsp_write, rsp_err, req, write_en, busy;
  logic [31:0]   rsp_rdata, wdata, rdata;
  logic [7:0]    addr;
  logic [CW-1:0] fifo_count;

  logic          slave_mode = 1'b0;
  logic [31:0]   rdata_fixed = 32'h0;
  logic          chk_en = 1'b0;
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  // A simple register slave: either a fixed word or a word derived from the address.
  assign rdata = slave_mode ? {24'hC0FFEE, addr} : rdata_fixed;

  cpm_reg_bus_master #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .req(req), .gnt(gnt),
    .write_en(write_en), .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy),
    .fifo_count(fifo_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct packed { logic w; logic [7:0] a; logic [31:0] d; } cmd_t;
  cmd_t        mq[$];
  cmd_t        m_cur = '0;
  bit          m_on_bus = 1'b0;
  bit          m_rsp = 1'b0;
  int          m_waited = 0;
  logic        m_rw = 1'b0, m_re = 1'b0;
  logic [31:0] m_rd = 32'h0;

  function automatic logic [31:0] slave_word(input logic [7:0] a);
    return slave_mode ? {24'hC0FFEE, a} : rdata_fixed;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_on_bus = 1'b0; m_rsp = 1'b0; m_cur = '0; m_waited = 0;
      m_rw = 1'b0; m_rd = 32'h0; m_re = 1'b0;
    end else begin
      bit accept;
      accept = cmd_valid && (mq.size() < FIFO_DEPTH);
      if (m_rsp) begin
        if (rsp_ready) begin
          m_rsp = 1'b0; m_rw = 1'b0; m_rd = 32'h0; m_re = 1'b0;
        end
      end else if (m_on_bus) begin
        if (gnt) begin
          m_on_bus = 1'b0; m_rsp = 1'b1; m_rw = m_cur.w; m_re = 1'b0;
          m_rd = m_cur.w ? 32'h0 : slave_word(m_cur.a);
        end else if (TO_EN && (m_waited + 1 == TIMEOUT_CYCLES)) begin
          m_on_bus = 1'b0; m_rsp = 1'b1; m_rw = m_cur.w; m_rd = 32'h0; m_re = 1'b1;
        end else begin
          m_waited++;
        end
      end else if (mq.size() > 0) begin
        m_cur = mq.pop_front(); m_on_bus = 1'b1; m_waited = 0;
      end
      if (accept) mq.push_back('{cmd_write, cmd_addr, cmd_wdata});
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req",        32'(req),        32'(m_on_bus));
      chk("write_en",   32'(write_en),   m_on_bus ? 32'(m_cur.w) : 32'h0);
      chk("addr",       32'(addr),       m_on_bus ? 32'(m_cur.a) : 32'h0);
      chk("wdata",      wdata,           m_on_bus ? m_cur.d : 32'h0);
      chk("rsp_valid",  32'(rsp_valid),  32'(m_rsp));
      chk("rsp_write",  32'(rsp_write),  32'(m_rw));
      chk("rsp_rdata",  rsp_rdata,       m_rd);
      chk("rsp_err",    32'(rsp_err),    32'(m_re));
      chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
      chk("cmd_ready",  32'(cmd_ready),  32'(mq.size() < FIFO_DEPTH));
      chk("busy",       32'(busy),       32'(m_on_bus || m_rsp || (mq.size() != 0)));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic push(input logic w, input logic [7:0] a, input logic [31:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    chk("push_accepted", 32'(n < 100), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!req && n < 50) begin tick(); n++; end
    chk("req_seen", 32'(req), 32'd1);
  endtask

  logic [32:0] got[$];
  logic [32:0] exp_rsp [5];

  initial begin
    int lat, hi, g, seen;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready",  32'(cmd_ready),  32'd1);
    chk("rst_req",        32'(req),        32'd0);
    chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    rst = 1'b0; chk_en = 1'b1;
    tick();

    // Write with gnt tied high: req two cycles after the push, single-cycle fire.
    gnt = 1'b1; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h04; cmd_wdata = 32'hDEADBEEF;
    lat = 0;
    do begin tick(); lat++; cmd_valid = 1'b0; end while (!req && lat < 20);
    chk("t1_req_latency", 32'(lat), 32'd2);
    chk("t1_write_en", 32'(write_en), 32'd1);
    chk("t1_addr", 32'(addr), 32'h04);
    chk("t1_wdata", wdata, 32'hDEADBEEF);
    tick();
    chk("t1_req_dropped", 32'(req), 32'd0);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_write", 32'(rsp_write), 32'd1);
    chk("t1_rsp_rdata", rsp_rdata, 32'h0);
    chk("t1_rsp_err", 32'(rsp_err), 32'd0);
    tick();
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // Read with gnt delayed: req held six cycles, address stable.
    gnt = 1'b0; rdata_fixed = 32'h12345678;
    push(1'b0, 8'h10, 32'h0);
    wait_req();
    hi = 1; g = 0;
    while (hi < 6 && g < 20) begin
      tick(); g++;
      if (req) hi++;
      chk("t2_addr_stable", 32'(addr), 32'h10);
    end
    chk("t2_req_held", 32'(req), 32'd1);
    gnt = 1'b1;
    tick();
    chk("t2_req_dropped", 32'(req), 32'd0);
    chk("t2_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("t2_rsp_write", 32'(rsp_write), 32'd0);
    gnt = 1'b0;
    tick();

    // Backpressure: five commands with the response stalled, then drain in order.
    rsp_ready = 1'b0; gnt = 1'b1; slave_mode = 1'b1;
    push(1'b1, 8'h20, 32'h11111111);
    push(1'b0, 8'h21, 32'h0);
    push(1'b1, 8'h22, 32'h22222222);
    push(1'b0, 8'h23, 32'h0);
    push(1'b0, 8'h24, 32'h0);
    chk("t3_fifo_full", 32'(fifo_count), 32'd4);
    chk("t3_cmd_ready_low", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h25; cmd_wdata = 32'h33333333;
    repeat (3) tick();
    chk("t3_no_bypass", 32'(fifo_count), 32'd4);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    g = 0;
    while (got.size() < 5 && g < 200) begin
      if (rsp_valid) got.push_back({rsp_write, rsp_rdata});
      tick(); g++;
    end
    exp_rsp = '{{1'b1, 32'h0}, {1'b0, 32'hC0FFEE21}, {1'b1, 32'h0},
                {1'b0, 32'hC0FFEE23}, {1'b0, 32'hC0FFEE24}};
    chk("t3_rsp_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) begin
        chk($sformatf("t3_rsp%0d_rdata", i), got[i][31:0], exp_rsp[i][31:0]);
        chk($sformatf("t3_rsp%0d_write", i), 32'(got[i][32]), 32'(exp_rsp[i][32]));
      end
    end
    slave_mode = 1'b0; gnt = 1'b0;
    repeat (2) tick();

`ifdef CPM_REG_MASTER_TIMEOUT_EN
    // Timeout: abort after TIMEOUT_CYCLES, next command completes normally.
    rdata_fixed = 32'hFFFFFFFF;
    push(1'b0, 8'h30, 32'h0);
    push(1'b1, 8'h31, 32'h00000055);
    wait_req();
    hi = 1;
    while (req && hi < 50) begin tick(); if (req) hi++; end
    chk("t4_req_cycles", 32'(hi), 32'd8);
    chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t4_rsp_err", 32'(rsp_err), 32'd1);
    chk("t4_rsp_rdata", rsp_rdata, 32'h0);
    gnt = 1'b1;
    wait_req();
    tick();
    chk("t4_next_rsp_err", 32'(rsp_err), 32'd0);
    chk("t4_next_rsp_write", 32'(rsp_write), 32'd1);
    gnt = 1'b0;
    tick();
    // gnt arriving on the very cycle the limit is reached completes normally.
    push(1'b0, 8'h32, 32'h0);
    wait_req();
    hi = 1; g = 0;
    while (hi < 8 && g < 20) begin tick(); g++; if (req) hi++; end
    chk("t4_edge_req_held", 32'(req), 32'd1);
    gnt = 1'b1;
    tick();
    chk("t4_edge_rsp_err", 32'(rsp_err), 32'd0);
    chk("t4_edge_rsp_rdata", rsp_rdata, 32'hFFFFFFFF);
    gnt = 1'b0;
    tick();
`endif

    // Reset mid-transaction with two commands queued.
    gnt = 1'b0; rsp_ready = 1'b1;
    push(1'b1, 8'h40, 32'hAAAA0000);
    push(1'b0, 8'h41, 32'h0);
    push(1'b0, 8'h42, 32'h0);
    chk("t5_req_before", 32'(req), 32'd1);
    chk("t5_queued_before", 32'(fifo_count), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_req", 32'(req), 32'd0);
    chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("t5_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0; gnt = 1'b1;
    seen = 0;
    repeat (10) begin tick(); if (rsp_valid || req) seen++; end
    chk("t5_no_activity", 32'(seen), 32'd0);
    chk("t5_busy_after", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/cpm_reg_bus_master.md
CPM_REG_BUS_MASTER -- requirements
Module: cpm_reg_bus_master

Interface
REQ-001 The module SHALL have one clock, clk, and an asynchronous, active-high reset, rst.
REQ-002 It SHALL have these parameters:
- FIFO_DEPTH, default 4: command FIFO entries, power of two, 2..16.
- TIMEOUT_CYCLES, default 64: cycles to wait for gnt before abort, 1..1023.
REQ-003 It SHALL have these ports:
- clk  input  1  clock.
- rst  input  1  async active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  FIFO can accept.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  8  register address.
- cmd_wdata  input  32  write data.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumer ready.
- rsp_write  output  1  echoes command type.
- rsp_rdata  output  32  read data (0 for writes and aborts).
- rsp_err  output  1  transaction aborted.
- req  output  1  register bus request.
- gnt  input  1  register bus grant.
- write_en  output  1  bus write strobe.
- addr  output  8  bus address.
- wdata  output  32  bus write data.
- rdata  input  32  bus read data.
- busy  output  1  state != IDLE or FIFO non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy.

Function
REQ-004 cmd_ready SHALL equal (fifo_count < FIFO_DEPTH); a push occurs when cmd_valid && cmd_ready; there is no full-FIFO bypass.
REQ-005 A simultaneous push and pop SHALL leave fifo_count unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-006 FSM states SHALL be IDLE, REQ and RESP.
REQ-007 IDLE -> REQ SHALL occur when fifo_count > 0: pop the head and register write_en/addr/wdata; req is 1 in the following cycle.
REQ-008 With the FSM idle and the FIFO empty, req SHALL first be high 2 cycles after the push edge.
REQ-009 In REQ, req, write_en, addr and wdata SHALL stay stable until fire (req && gnt).
REQ-010 On the fire edge: rsp_rdata <= (write_en ? 0 : rdata), rsp_write <= write_en, rsp_err <= 0, req <= 0, go to RESP.
REQ-011 In RESP, rsp_valid SHALL be 1 and all rsp_* outputs SHALL be held until rsp_ready; then go to IDLE; req SHALL be low for at least one cycle between transactions.
REQ-012 At most one transaction SHALL be outstanding; responses SHALL return in command order.
REQ-013 gnt SHALL be ignored while req == 0.
REQ-014 In IDLE, write_en, addr and wdata SHALL be 0.

Reset
REQ-015 Asserting rst SHALL immediately set state to IDLE, empty the FIFO, and drive every output to 0 except cmd_ready, which is 1.
REQ-016 Reset mid-transaction SHALL discard the in-flight command and all queued commands, and SHALL NOT produce a response.
REQ-017 Operation SHALL resume on the first clk edge after rst deasserts.

Configuration
REQ-018 With CPM_REG_MASTER_TIMEOUT_EN defined, a 10-bit wait counter SHALL clear on entry to REQ and increment each REQ cycle without gnt.
REQ-019 With the macro defined, reaching TIMEOUT_CYCLES without gnt SHALL drop req, set rsp_err = 1 and rsp_rdata = 0, and go to RESP.
REQ-020 With the macro defined, gnt in the same cycle the count is reached SHALL win: normal completion, rsp_err = 0.
REQ-021 Without the macro, no counter SHALL exist, REQ SHALL wait for gnt indefinitely, and rsp_err SHALL be tied to 0.

Verification
REQ-022 Write addr 0x04, data 0xDEADBEEF, gnt tied 1 -> req rises 2 cycles after the push; one-cycle fire with write_en=1, addr=0x04, wdata=0xDEADBEEF; rsp_valid next cycle with rsp_write=1, rsp_rdata=0, rsp_err=0.
REQ-023 Read addr 0x10, gnt delayed 5 cycles, rdata=0x12345678 at fire -> req held 6 cycles with addr stable; rsp_rdata=0x12345678.
REQ-024 5 pushes with rsp_ready=0 (FIFO_DEPTH=4) -> cmd_ready low after the 4th queued entry; all 5 commands complete in order once rsp_ready=1; fifo_count never exceeds 4.
REQ-025 Macro defined, TIMEOUT_CYCLES=8, gnt=0 -> req drops after 8 cycles; rsp_err=1, rsp_rdata=0; next queued command proceeds normally.
REQ-026 rst pulsed while req=1 with 2 entries queued -> req, rsp_valid and fifo_count are 0 immediately; no response after release; busy=0.
